ili934x_spi_wr: RTL and testbench
=================================

Name: ili934x_spi_wr

Overview:
Downstream write engine for the ILI934x panel path. Consumes the wr_item_t byte stream (command/data flag plus byte) from the window/stream controller and buffers it in a small FIFO. Serialises each byte onto the panel's 4-wire SPI write interface (CSX, DCX, SCL, SDA) in SPI mode 0, MSB first. Exports the FIFO-headroom hint that feeds the upstream sink_can_accept input.

Parameters:
CLK_DIV, 2, clk cycles per SCL half-period; must be >= 1; byte time = 16*CLK_DIV cycles
FIFO_DEPTH, 16, item FIFO entries; power of two, >= 4
FIFO_GUARD, 2, sink_can_accept is low when free entries <= FIFO_GUARD
CS_IDLE_CYCLES, 2, minimum CSX-high cycles between transactions

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
item_valid  in  1  upstream byte valid
item  in  wr_item_t (9)  {is_cmd, byte_pack[7:0]}
item_ready  out  1  FIFO not full
sink_can_accept  out  1  free entries > FIFO_GUARD
lcd_csx  out  1  chip select, active-low
lcd_dcx  out  1  0 = command, 1 = data
lcd_scl  out  1  serial clock, idle low
lcd_sda  out  1  serial data
busy  out  1  FIFO non-empty or transfer/gap in progress
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset values: lcd_csx=1, lcd_dcx=0, lcd_scl=0, lcd_sda=0, busy=0, fifo_level=0, item_ready=1, sink_can_accept=1. FIFO pointers cleared.
- Push on item_valid && item_ready. item_ready = !full, combinational from the registered count. A push when full is impossible by construction.
- sink_can_accept = (FIFO_DEPTH - fifo_level) > FIFO_GUARD, combinational from the registered count.
- Same-cycle push and pop: level unchanged, order preserved. The FIFO is first-word-fall-through internally; a pop reads the head.
- FSM states: S_IDLE, S_LOAD, S_SHIFT, S_GAP.
- S_IDLE: when the FIFO is non-empty, pop the head into shift_q and dcx_q, then go to S_LOAD.
- S_LOAD (1 cycle): lcd_csx<=0, lcd_dcx<=~is_cmd, lcd_sda<=bit7, lcd_scl<=0, div_cnt<=0, bit_cnt<=7, phase<=LOW. Go to S_SHIFT.
- S_SHIFT: div_cnt counts 0..CLK_DIV-1. On wrap, toggle the phase.
  - LOW->HIGH: lcd_scl<=1. The panel samples on the rising edge.
  - HIGH->LOW with bit_cnt>0: lcd_scl<=0, lcd_sda<=next bit, bit_cnt--.
- End of bit 0's high phase:
  - FIFO non-empty: pop and reload the next byte in the same cycle (scl<=0, sda<=new bit7, dcx updated) and stay in S_SHIFT. CSX stays low, so there is no gap between back-to-back bytes.
  - FIFO empty: lcd_scl<=0, lcd_csx<=1, go to S_GAP.
- S_GAP: hold CSX high for CS_IDLE_CYCLES cycles, then go to S_IDLE.
- DCX changes only while SCL is low and never mid-byte.
- Throughput: back-to-back bytes take exactly 16*CLK_DIV cycles each. The first byte of a burst adds 1 cycle of S_IDLE pop plus 1 cycle of S_LOAD.
- busy = (state != S_IDLE) || fifo_level != 0.
- Reset asserted mid-byte: outputs return to reset values asynchronously and the FIFO is flushed. The partial byte is lost; there is no recovery of it.
- Counter widths: div_cnt $clog2(CLK_DIV+1), bit_cnt 3 bits. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- ili934x_pkg: wr_item_t (already shared). Add localparams for SPI phase encoding and the state enum type ili934x_spi_st_e.
- One sub-module: ili934x_byte_fifo. Parameterised synchronous FIFO with DEPTH and WIDTH=$bits(wr_item_t), count output, and full/empty flags.
- Top level holds the FSM and serialiser.

Test Plan:
1. Single command item {1,0x2A}, CLK_DIV=2:
   - CSX low for 32 cycles; DCX=0 throughout.
   - SDA sampled on SCL rising edges reads 0,0,1,0,1,0,1,0.
   - CSX high for >=2 cycles afterwards.
2. Burst 2A,00,00,00,EF (cmd then 4 data) pushed back-to-back:
   - CSX low continuously for 5*32 cycles.
   - DCX=0 for the first byte only; decoded bytes match in order.
3. Overflow pressure: push 24 items with item_valid held high:
   - item_ready drops when level=16.
   - sink_can_accept drops when level>=14.
   - All 24 bytes appear on SDA in order, none duplicated.
4. Idle gap: one byte, wait 100 cycles, another byte:
   - Two separate CSX-low windows, each 32 cycles.
   - CSX high between them for >= CS_IDLE_CYCLES.
5. Reset asserted at bit 4 of a byte with 3 queued:
   - CSX=1, SCL=0, fifo_level=0 immediately.
   - After release, a fresh byte 0x55 transfers correctly.
6. Integration with the window stream controller: 2C then pixel 0xF800 produce bytes 2C(DCX=0), F8(DCX=1), 00(DCX=1).

Source files
------------

// File: rtl/ili934x_pkg.sv
// ili934x_pkg: types shared along the ILI934x panel write path.
//   wr_item_t        - one byte of the panel stream plus its command flag
//   SPI_PHASE_*      - encoding of the serial clock half-period phase
//   ili934x_spi_st_e - state type of the SPI write engine
package ili934x_pkg;

  typedef struct packed {
    logic       is_cmd;
    logic [7:0] byte_pack;
  } wr_item_t;

  localparam logic SPI_PHASE_LOW  = 1'b0;
  localparam logic SPI_PHASE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } ili934x_spi_st_e;

endpackage

// File: rtl/ili934x_byte_fifo.sv
// ili934x_byte_fifo: small synchronous first-word-fall-through FIFO.
// The head entry is always visible on rd_data while empty is low; rd_en
// consumes it. Simultaneous write and read leave the count unchanged.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers/count)
//   wr_en, wr_data   write strobe (caller guarantees !full) and data
//   rd_en, rd_data   pop strobe (caller guarantees !empty) and head data
//   count            occupied entries
//   full, empty      status flags derived from the registered count
module ili934x_byte_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 9,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers are DEPTH-sized (power of two) so they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/ili934x_spi_wr.sv
// ili934x_spi_wr: write engine for the ILI934x 4-wire SPI interface.
// Buffers command/data bytes in a FIFO and shifts each one out MSB first in
// SPI mode 0 (SCL idles low, panel samples on the rising edge). Bytes that
// are already queued when the previous one finishes follow with CSX held
// low and no idle clocks; otherwise CSX is raised for a short guard gap.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   item_valid, item      upstream byte stream, accepted when item_ready
//   item_ready            FIFO not full
//   sink_can_accept       more than FIFO_GUARD entries free
//   lcd_csx/dcx/scl/sda   panel SPI pins (CSX active-low, DCX 0 = command)
//   busy                  bytes queued or a transfer/gap in progress
//   fifo_level            occupied FIFO entries
module ili934x_spi_wr
  import ili934x_pkg::*;
#(
  parameter  int CLK_DIV        = 2,
  parameter  int FIFO_DEPTH     = 16,
  parameter  int FIFO_GUARD     = 2,
  parameter  int CS_IDLE_CYCLES = 2,
  localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             item_valid,
  input  wr_item_t         item,
  output logic             item_ready,
  output logic             sink_can_accept,
  output logic             lcd_csx,
  output logic             lcd_dcx,
  output logic             lcd_scl,
  output logic             lcd_sda,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // A zero-length gap still spends one cycle in S_GAP.
  localparam int GAP_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((CS_IDLE_CYCLES > 0) ? CS_IDLE_CYCLES - 1 : 0);

  // FIFO interface
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] fifo_rd_data;
  wr_item_t   head;

  ili934x_spi_st_e  state_reg,    state_next;
  logic [7:0]       shift_reg,    shift_next;
  logic             dcx_hold_reg, dcx_hold_next;
  logic [DIV_W-1:0] div_cnt_reg,  div_cnt_next;
  logic [2:0]       bit_cnt_reg,  bit_cnt_next;
  logic             phase_reg,    phase_next;
  logic [GAP_W-1:0] gap_cnt_reg,  gap_cnt_next;
  logic             csx_reg,      csx_next;
  logic             dcx_reg,      dcx_next;
  logic             scl_reg,      scl_next;
  logic             sda_reg,      sda_next;

  assign push = item_valid && !fifo_full;
  assign head = fifo_rd_data;

  ili934x_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_item_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (item),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      shift_reg    <= '0;
      dcx_hold_reg <= 1'b0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      phase_reg    <= SPI_PHASE_LOW;
      gap_cnt_reg  <= '0;
      csx_reg      <= 1'b1;
      dcx_reg      <= 1'b0;
      scl_reg      <= 1'b0;
      sda_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      dcx_hold_reg <= dcx_hold_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      phase_reg    <= phase_next;
      gap_cnt_reg  <= gap_cnt_next;
      csx_reg      <= csx_next;
      dcx_reg      <= dcx_next;
      scl_reg      <= scl_next;
      sda_reg      <= sda_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    dcx_hold_next = dcx_hold_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    phase_next    = phase_reg;
    gap_cnt_next  = gap_cnt_reg;
    csx_next      = csx_reg;
    dcx_next      = dcx_reg;
    scl_next      = scl_reg;
    sda_next      = sda_reg;
    pop           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = head.byte_pack;
          dcx_hold_next = ~head.is_cmd;
          state_next    = S_LOAD;
        end
      end

      S_LOAD: begin
        csx_next     = 1'b0;
        dcx_next     = dcx_hold_reg;
        sda_next     = shift_reg[7];
        scl_next     = 1'b0;
        div_cnt_next = '0;
        bit_cnt_next = 3'd7;
        phase_next   = SPI_PHASE_LOW;
        state_next   = S_SHIFT;
      end

      S_SHIFT: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (phase_reg == SPI_PHASE_LOW) begin
            phase_next = SPI_PHASE_HIGH;
            scl_next   = 1'b1;
          end else begin
            phase_next = SPI_PHASE_LOW;
            scl_next   = 1'b0;
            if (bit_cnt_reg != 3'd0) begin
              bit_cnt_next = bit_cnt_reg - 3'd1;
              sda_next     = shift_reg[bit_cnt_reg - 3'd1];
            end else if (!fifo_empty) begin
              // Chain the next byte on the falling edge that ends bit 0;
              // DCX may change here because SCL is going low.
              pop           = 1'b1;
              shift_next    = head.byte_pack;
              dcx_hold_next = ~head.is_cmd;
              dcx_next      = ~head.is_cmd;
              sda_next      = head.byte_pack[7];
              bit_cnt_next  = 3'd7;
            end else begin
              csx_next     = 1'b1;
              gap_cnt_next = '0;
              state_next   = S_GAP;
            end
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign item_ready      = !fifo_full;
  assign sink_can_accept = (FIFO_DEPTH - int'(fifo_level)) > FIFO_GUARD;
  assign busy            = (state_reg != S_IDLE) || (fifo_level != '0);
  assign lcd_csx         = csx_reg;
  assign lcd_dcx         = dcx_reg;
  assign lcd_scl         = scl_reg;
  assign lcd_sda         = sda_reg;

endmodule

// File: tb/tb_ili934x_spi_wr.sv
// tb_ili934x_spi_wr: scoreboard bench for the ILI934x SPI write engine.
// The stimulus process pushes directed items and queues the expected
// {DCX, byte} pair on acceptance; the monitor decodes the SPI pins on SCL
// rising edges and pops/compares each completed byte, and also checks CSX
// window lengths, the inter-window gap and the FIFO headroom flags.
module tb_ili934x_spi_wr;
  import ili934x_pkg::*;

  localparam int CLK_DIV        = 2;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_GUARD     = 2;
  localparam int CS_IDLE_CYCLES = 2;
  localparam int BYTE_CYC       = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       item_valid = 1'b0;
  wr_item_t   item = '0;
  logic       item_ready;
  logic       sink_can_accept;
  logic       lcd_csx;
  logic       lcd_dcx;
  logic       lcd_scl;
  logic       lcd_sda;
  logic       busy;
  logic [4:0] fifo_level;

  always #5 clk = ~clk;

  ili934x_spi_wr #(
    .CLK_DIV        (CLK_DIV),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_GUARD     (FIFO_GUARD),
    .CS_IDLE_CYCLES (CS_IDLE_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .item_valid      (item_valid),
    .item            (item),
    .item_ready      (item_ready),
    .sink_can_accept (sink_can_accept),
    .lcd_csx         (lcd_csx),
    .lcd_dcx         (lcd_dcx),
    .lcd_scl         (lcd_scl),
    .lcd_sda         (lcd_sda),
    .busy            (busy),
    .fifo_level      (fifo_level)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];

  // monitor state
  int         mon_bits = 0;
  logic [7:0] mon_byte = '0;
  logic       mon_dcx0 = 1'b0;
  bit         dcx_ok = 1'b1;
  int         low_cnt = 0;
  int         high_cnt = 0;
  int         win_bytes = 0;
  int         last_win_bytes = 0;
  int         win_count = 0;
  bit         seen_window = 1'b0;
  logic       prev_scl = 1'b0;
  logic       prev_csx = 1'b1;
  logic       prev_dcx = 1'b0;
  bit         lvl_chk_en = 1'b0;
  int         max_level = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_bits    = 0;
        low_cnt     = 0;
        high_cnt    = 0;
        win_bytes   = 0;
        seen_window = 1'b0;
        prev_scl    = 1'b0;
        prev_csx    = 1'b1;
        prev_dcx    = 1'b0;
      end else begin
        if (!lcd_csx && prev_csx && seen_window)
          chk_eq("csx_gap_ge_idle", 32'(high_cnt >= CS_IDLE_CYCLES), 1);
        if (lcd_dcx != prev_dcx)
          chk_eq("dcx_change_scl_low", lcd_scl, 0);
        if (!lcd_csx) begin
          low_cnt++;
          if (lcd_scl && !prev_scl) begin
            if (mon_bits == 0) begin
              mon_dcx0 = lcd_dcx;
              dcx_ok   = 1'b1;
            end else if (lcd_dcx != mon_dcx0) begin
              dcx_ok = 1'b0;
            end
            mon_byte = {mon_byte[6:0], lcd_sda};
            mon_bits++;
            if (mon_bits == 8) begin
              mon_bits = 0;
              win_bytes++;
              chk_eq("dcx_stable_in_byte", 32'(dcx_ok), 1);
              if (exp_q.size() == 0) begin
                chk_eq("unexpected_byte", {23'd0, mon_dcx0, mon_byte}, 32'h0000_0200);
              end else begin
                exp = exp_q.pop_front();
                chk_eq("spi_byte", {23'd0, mon_dcx0, mon_byte}, {23'd0, exp});
              end
            end
          end
        end else begin
          if (!prev_csx) begin
            chk_eq("csx_window_len", low_cnt, BYTE_CYC * win_bytes);
            chk_eq("csx_window_whole_bytes", mon_bits, 0);
            last_win_bytes = win_bytes;
            win_count++;
            low_cnt     = 0;
            win_bytes   = 0;
            high_cnt    = 0;
            mon_bits    = 0;
            seen_window = 1'b1;
          end
          high_cnt++;
        end
        if (lvl_chk_en) begin
          chk_eq("item_ready_vs_level", item_ready, 32'(fifo_level != 5'd16));
          chk_eq("sink_can_accept_vs_level", sink_can_accept, 32'(fifo_level < 5'd14));
          if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        prev_scl = lcd_scl;
        prev_csx = lcd_csx;
        prev_dcx = lcd_dcx;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input bit is_cmd, input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    item_valid     = 1'b1;
    item.is_cmd    = is_cmd;
    item.byte_pack = b;
    while (!item_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!item_ready) begin
      chk_eq("push_timeout", 0, 1);
      item_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({~is_cmd, b});
      #1;
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    item_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || !lcd_csx) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk_eq({name, "_all_bytes_seen"}, exp_q.size(), 0);
    chk_eq({name, "_idle"}, busy, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int wc;
    // reset values
    repeat (3) @(negedge clk);
    chk_eq("rst_csx", lcd_csx, 1);
    chk_eq("rst_dcx", lcd_dcx, 0);
    chk_eq("rst_scl", lcd_scl, 0);
    chk_eq("rst_sda", lcd_sda, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_level", fifo_level, 0);
    chk_eq("rst_item_ready", item_ready, 1);
    chk_eq("rst_sink_can_accept", sink_can_accept, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single command 0x2A
    push(1'b1, 8'h2A);
    idle_in();
    wait_done("t1");
    chk_eq("t1_window_bytes", last_win_bytes, 1);

    // 2: command then four data bytes, one continuous CSX window
    push(1'b1, 8'h2A);
    push(1'b0, 8'h00);
    push(1'b0, 8'h00);
    push(1'b0, 8'h00);
    push(1'b0, 8'hEF);
    idle_in();
    wait_done("t2");
    chk_eq("t2_window_bytes", last_win_bytes, 5);

    // 3: 24 items with valid held high against a full FIFO
    lvl_chk_en = 1'b1;
    push(1'b1, 8'h2C);
    for (int i = 1; i < 24; i++) push(1'b0, 8'(i * 11 + 5));
    idle_in();
    wait_done("t3");
    lvl_chk_en = 1'b0;
    chk_eq("t3_max_level", max_level, 16);
    chk_eq("t3_window_bytes", last_win_bytes, 24);

    // 4: two bytes separated by 100 idle cycles
    wc = win_count;
    push(1'b0, 8'hA5);
    idle_in();
    repeat (100) @(negedge clk);
    push(1'b0, 8'h5A);
    idle_in();
    wait_done("t4");
    chk_eq("t4_window_count", win_count - wc, 2);
    chk_eq("t4_window_bytes", last_win_bytes, 1);

    // 5: reset at bit 4 of a byte with three queued behind it
    push(1'b1, 8'h2A);
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    push(1'b0, 8'h33);
    idle_in();
    n = 0;
    while (mon_bits != 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_eq("t5_reached_bit4", mon_bits, 4);
    chk_eq("t5_level_before_reset", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t5_csx_in_reset", lcd_csx, 1);
    chk_eq("t5_scl_in_reset", lcd_scl, 0);
    chk_eq("t5_level_in_reset", fifo_level, 0);
    chk_eq("t5_busy_in_reset", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b0, 8'h55);
    idle_in();
    wait_done("t5");
    chk_eq("t5_window_bytes", last_win_bytes, 1);

    // 6: RAMWR command then one RGB565 pixel 0xF800
    push(1'b1, 8'h2C);
    push(1'b0, 8'hF8);
    push(1'b0, 8'h00);
    idle_in();
    wait_done("t6");
    chk_eq("t6_window_bytes", last_win_bytes, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
